// File: rtl/mio_bus_if.sv
// CPU-side MIO bus: request/response signals between the multi-cycle controller and the responder.
interface mio_bus_if;
    logic        mem_r;
    logic        mem_w;
    logic [31:0] addr_bus;
    logic [31:0] data_to_mem;
    logic [31:0] data_from_mem;
    logic        mio_ready;

    modport master (
        output mem_r, mem_w, addr_bus, data_to_mem,
        input  data_from_mem, mio_ready
    );

    modport slave (
        input  mem_r, mem_w, addr_bus, data_to_mem,
        output data_from_mem, mio_ready
    );
endinterface

// File: rtl/mio_bus_resp.sv
// MIO bus responder: decodes CPU requests to block RAM, switches, LED register and free-running
// counter, and generates mio_ready. Define MIO_BUS_ERR_EN for the sticky bus_err output.
module mio_bus_resp #(
    parameter int unsigned RAM_AW  = 10,
    parameter int unsigned RAM_LAT = 1,
    parameter int unsigned LED_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    mio_bus_if.slave          bus,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    input  logic [31:0]       ram_dout,
    input  logic [15:0]       sw_in,
`ifdef MIO_BUS_ERR_EN
    output logic              bus_err,
`endif
    output logic [LED_W-1:0]  led_out
);

    localparam logic [31:0] SwAddr  = 32'hE000_0000;
    localparam logic [31:0] LedAddr = 32'hF000_0000;
    localparam logic [31:0] CntAddr = 32'hF000_0004;
`ifdef MIO_BUS_ERR_EN
    localparam logic [31:0] UnmappedData = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] UnmappedData = 32'h0000_0000;
`endif

    typedef enum logic [1:0] {StIdle, StRwait, StResp} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q;
    logic        op_w_q;
    logic [31:0] data_q;
    logic [31:0] counter_q;
    logic [15:0] sw_meta_q, sw_sync_q;
    logic [LED_W-1:0] led_q;

    logic [31:0] word_addr;
    logic        req, accept;
    logic        is_ram, is_sw, is_led, is_cnt, is_unmapped;
    logic [31:0] periph_rdata;
    logic        unused_addr;

    assign word_addr   = {bus.addr_bus[31:2], 2'b00};
    assign unused_addr = ^bus.addr_bus[1:0];
    assign req         = bus.mem_r | bus.mem_w;
    assign accept      = (state_q == StIdle) && req;
    assign is_ram      = (bus.addr_bus[31:28] == 4'h0);
    assign is_sw       = (word_addr == SwAddr);
    assign is_led      = (word_addr == LedAddr);
    assign is_cnt      = (word_addr == CntAddr);
    assign is_unmapped = !(is_ram || is_sw || is_led || is_cnt);

    always_comb begin
        periph_rdata = UnmappedData;
        if (is_sw)       periph_rdata = {16'h0000, sw_sync_q};
        else if (is_led) periph_rdata = 32'(led_q);
        else if (is_cnt) periph_rdata = counter_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req) state_d = is_ram ? StRwait : StResp;
            StRwait: if (cnt_q == 3'd1) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Peripherals always complete straight out of IDLE, so they act on the live bus inputs;
    // only RAM accesses need the latched address, data and op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            op_w_q    <= 1'b0;
            data_q    <= '0;
            counter_q <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            led_q     <= '0;
            ram_addr  <= '0;
            ram_din   <= '0;
            ram_we    <= 1'b0;
        end else begin
            ram_we    <= 1'b0;
            counter_q <= counter_q + 32'd1;
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
            if (accept) begin
                op_w_q <= bus.mem_w;
                cnt_q  <= 3'(RAM_LAT);
                if (is_ram) begin
                    ram_addr <= bus.addr_bus[RAM_AW+1:2];
                    if (bus.mem_w) begin
                        ram_din <= bus.data_to_mem;
                        ram_we  <= 1'b1;
                    end
                end else if (bus.mem_w) begin
                    if (is_led) led_q <= bus.data_to_mem[LED_W-1:0];
                    if (is_cnt) counter_q <= bus.data_to_mem;
                end else begin
                    data_q <= periph_rdata;
                end
            end
            if (state_q == StRwait) begin
                cnt_q <= cnt_q - 3'd1;
                if (cnt_q == 3'd1 && !op_w_q) data_q <= ram_dout;
            end
        end
    end

`ifdef MIO_BUS_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) bus_err <= 1'b0;
        else if (accept && (is_unmapped || (bus.mem_r && bus.mem_w))) bus_err <= 1'b1;
    end
`endif

    assign bus.mio_ready     = (state_q == StResp);
    assign bus.data_from_mem = data_q;
    assign led_out           = led_q;

endmodule

// File: tb/tb_mio_bus_resp.sv
// Directed self-checking bench for mio_bus_resp with a behavioural RAM (RAM_LAT = 1).
module tb_mio_bus_resp;

    logic        clk;
    logic        reset;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din;
    logic        ram_we;
    logic [31:0] ram_dout;
    logic [15:0] sw_in;
    logic [15:0] led_out;
`ifdef MIO_BUS_ERR_EN
    logic        bus_err;
`endif

    int checks = 0;
    int failures = 0;
    int edges;
    int we_count;
    int rdy_count;
    logic [9:0] last_we_addr;
    logic [31:0] mem [0:1023];

    mio_bus_if bus ();

    mio_bus_resp #(
        .RAM_AW  (10),
        .RAM_LAT (1),
        .LED_W   (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_dout (ram_dout),
        .sw_in    (sw_in),
`ifdef MIO_BUS_ERR_EN
        .bus_err  (bus_err),
`endif
        .led_out  (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_dout = mem[ram_addr];

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_din;
            we_count      <= we_count + 1;
            last_we_addr  <= ram_addr;
        end
        if (bus.mio_ready) rdy_count <= rdy_count + 1;
        edges <= reset ? 0 : edges + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called #1 after an edge with the DUT idle; returns cycles to mio_ready and the read data,
    // then steps past RESP so the DUT is idle again.
    task automatic txn(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd);
        bus.mem_w = w;
        bus.mem_r = r;
        bus.addr_bus = a;
        bus.data_to_mem = d;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.mio_ready && lat < 20);
        rd = bus.data_from_mem;
        bus.mem_w = 1'b0;
        bus.mem_r = 1'b0;
        tick(1);
    endtask

    initial begin
        int lat;
        int k;
        int we0;
        int rdy0;
        logic [31:0] rd;

        we_count = 0;
        rdy_count = 0;
        edges = 0;
        last_we_addr = '0;
        reset = 1'b1;
        sw_in = 16'h0000;
        bus.mem_r = 1'b0;
        bus.mem_w = 1'b0;
        bus.addr_bus = '0;
        bus.data_to_mem = '0;

        tick(2);
        check("rst_ready", 32'(bus.mio_ready), 32'h0);
        check("rst_data", bus.data_from_mem, 32'h0);
        check("rst_ram_we", 32'(ram_we), 32'h0);
        check("rst_ram_addr", 32'(ram_addr), 32'h0);
        reset = 1'b0;

        tick(5);
        check("idle_ready", 32'(bus.mio_ready), 32'h0);
        check("idle_led", 32'(led_out), 32'h0);
        check("idle_data", bus.data_from_mem, 32'h0);
`ifdef MIO_BUS_ERR_EN
        check("idle_bus_err", 32'(bus_err), 32'h0);
`endif

        // Counter read returns the number of edges since reset release.
        k = edges;
        txn(1'b0, 1'b1, 32'hF000_0004, 32'h0, lat, rd);
        check("cnt_rd_lat", 32'(lat), 32'd1);
        check("cnt_rd_val", rd, 32'(k));

        // RAM write then read.
        we0 = we_count;
        txn(1'b1, 1'b0, 32'h0000_0010, 32'h1234_5678, lat, rd);
        check("ram_wr_lat", 32'(lat), 32'd2);
        check("ram_we_pulses", 32'(we_count - we0), 32'd1);
        check("ram_we_addr", 32'(last_we_addr), 32'd4);
        txn(1'b0, 1'b1, 32'h0000_0010, 32'h0, lat, rd);
        check("ram_rd_lat", 32'(lat), 32'd2);
        check("ram_rd_data", rd, 32'h1234_5678);

        // LED write leaves data_from_mem untouched.
        txn(1'b1, 1'b0, 32'hF000_0000, 32'hFFFF_A5A5, lat, rd);
        check("led_wr_lat", 32'(lat), 32'd1);
        check("led_wr_hold", rd, 32'h1234_5678);
        check("led_out", 32'(led_out), 32'h0000_A5A5);
        txn(1'b0, 1'b1, 32'hF000_0002, 32'h0, lat, rd);
        check("led_rd", rd, 32'h0000_A5A5);

        // Counter load and wrap: FFFFFFFE in RESP, FFFFFFFF, 0, 1 at the read.
        txn(1'b1, 1'b0, 32'hF000_0004, 32'hFFFF_FFFE, lat, rd);
        check("cnt_wr_lat", 32'(lat), 32'd1);
        tick(2);
        txn(1'b0, 1'b1, 32'hF000_0004, 32'h0, lat, rd);
        check("cnt_wrap", rd, 32'h0000_0001);

        // Switch synchroniser: settled value, then the stale value right after a change.
        sw_in = 16'h00C3;
        tick(3);
        txn(1'b0, 1'b1, 32'hE000_0000, 32'h0, lat, rd);
        check("sw_rd", rd, 32'h0000_00C3);
        sw_in = 16'h5A5A;
        txn(1'b0, 1'b1, 32'hE000_0000, 32'h0, lat, rd);
        check("sw_stale", rd, 32'h0000_00C3);
        txn(1'b1, 1'b0, 32'hE000_0000, 32'hFFFF_FFFF, lat, rd);
        check("sw_wr_ack", 32'(lat), 32'd1);
        txn(1'b0, 1'b1, 32'hE000_0000, 32'h0, lat, rd);
        check("sw_rd_new", rd, 32'h0000_5A5A);

        // Both requests high: the write wins.
        txn(1'b1, 1'b1, 32'hF000_0000, 32'h0000_0042, lat, rd);
        check("both_lat", 32'(lat), 32'd1);
        check("both_led", 32'(led_out), 32'h0000_0042);
        check("both_data", rd, 32'h0000_5A5A);
`ifdef MIO_BUS_ERR_EN
        check("both_bus_err", 32'(bus_err), 32'h1);
`endif

        // Reset during RWAIT aborts the write before the RAM samples it.
        txn(1'b1, 1'b0, 32'h0000_0020, 32'h0000_1111, lat, rd);
        we0 = we_count;
        rdy0 = rdy_count;
        bus.mem_w = 1'b1;
        bus.addr_bus = 32'h0000_0020;
        bus.data_to_mem = 32'h0000_CAFE;
        tick(1);
        reset = 1'b1;
        bus.mem_w = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(2);
        check("abort_we", 32'(we_count - we0), 32'd0);
        check("abort_ready", 32'(rdy_count - rdy0), 32'd0);
        check("abort_led", 32'(led_out), 32'h0);
        txn(1'b0, 1'b1, 32'h0000_0020, 32'h0, lat, rd);
        check("abort_idle_lat", 32'(lat), 32'd2);
        check("abort_ram_keep", rd, 32'h0000_1111);

        // Unmapped read.
        txn(1'b0, 1'b1, 32'h8000_0000, 32'h0, lat, rd);
        check("unmap_lat", 32'(lat), 32'd1);
`ifdef MIO_BUS_ERR_EN
        check("unmap_data", rd, 32'hDEAD_BEEF);
        check("unmap_bus_err", 32'(bus_err), 32'h1);
        txn(1'b0, 1'b1, 32'hF000_0000, 32'h0, lat, rd);
        check("bus_err_sticky", 32'(bus_err), 32'h1);
`else
        check("unmap_data", rd, 32'h0);
        txn(1'b1, 1'b0, 32'h8000_0000, 32'h1, lat, rd);
        check("unmap_wr_lat", 32'(lat), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
